// File: rtl/sparse_pkg.sv
// sparse_pkg: shared sparse-datapath constants and lane address-window helper
package sparse_pkg;
  localparam int CHANNEL_NUM = 4;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;
  localparam int FIFO_DEPTH = 4;
  localparam int LANE_STRIDE = 256;
  localparam int LANE_W = $clog2(CHANNEL_NUM);
  localparam int OFF_W = $clog2(LANE_STRIDE);
  function automatic logic [ADDR_W-1:0] lane_base(input logic [LANE_W-1:0] lane);
    return ADDR_W'(lane) << OFF_W;
  endfunction
endpackage

// File: rtl/result_writer_lane_fifo.sv
// lane_fifo: single-clock count-based FIFO with first-word-fall-through head
module lane_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rd, wr;
  logic [PW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (PW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rd];
  // pointers and occupancy; push is judged on the pre-edge count, so a full lane drops even when popped
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  // storage needs no reset: slots are only read once written
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
endmodule

// File: rtl/result_writer.sv
// result_writer: round-robin drain of per-lane result FIFOs into a single-port RAM; WB_READY_EN adds mem_ready backpressure
module result_writer
  import sparse_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNEL_NUM-1:0]        push,
  input  logic [CHANNEL_NUM*DATA_W-1:0] din,
`ifdef WB_READY_EN
  input  logic                        mem_ready,
`endif
  output logic [CHANNEL_NUM-1:0]        full,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_din,
  output logic                        idle
);
  logic [CHANNEL_NUM-1:0] empty, pop;
  logic [DATA_W-1:0] head [CHANNEL_NUM];
  logic [OFF_W-1:0] offset [CHANNEL_NUM];
  logic [LANE_W-1:0] rr_ptr, sel;
  logic found, adv;
`ifdef WB_READY_EN
  assign adv = !mem_we || mem_ready;
`else
  assign adv = 1'b1;
`endif
  for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_lane
    lane_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(push[g]),
      .pop(pop[g]),
      .din(din[g*DATA_W +: DATA_W]),
      .head(head[g]),
      .full(full[g]),
      .empty(empty[g])
    );
    assign pop[g] = adv && found && sel == LANE_W'(g);
  end
  assign idle = &empty && !mem_we;
  // rotating priority: first non-empty lane at or after rr_ptr
  always_comb begin
    found = 1'b0;
    sel = '0;
    for (int k = 0; k < CHANNEL_NUM; k++)
      if (!found && !empty[(int'(rr_ptr) + k) % CHANNEL_NUM]) begin
        found = 1'b1;
        sel = LANE_W'((int'(rr_ptr) + k) % CHANNEL_NUM);
      end
  end
  // write port registers, per-lane offsets and priority pointer; offsets wrap inside their window
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_din <= '0;
      rr_ptr <= '0;
      for (int i = 0; i < CHANNEL_NUM; i++) offset[i] <= '0;
    end else if (adv) begin
      mem_we <= found;
      if (found) begin
        mem_addr <= lane_base(sel) | ADDR_W'(offset[sel]);
        mem_din <= head[sel];
        offset[sel] <= offset[sel] + 1'b1;
        rr_ptr <= sel == LANE_W'(CHANNEL_NUM - 1) ? '0 : sel + 1'b1;
      end
    end
endmodule

// File: tb/tb_result_writer.sv
// tb_result_writer: randomized and directed checks of result_writer against a queue-based reference
module tb_result_writer;
  import sparse_pkg::*;
  logic clk = 0, rst = 0;
  logic [3:0] push = 0;
  logic [31:0] din = 0;
  logic mem_ready = 1;
  logic [3:0] full;
  logic mem_we, idle;
  logic [9:0] mem_addr;
  logic [7:0] mem_din;
  int total = 0, bad = 0;
  logic [7:0] q [4][$];
  int off [4];
  int rr, ea, ed;
  logic ew;

  always #5 clk = ~clk;

  result_writer dut (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(din),
`ifdef WB_READY_EN
    .mem_ready(mem_ready),
`endif
    .full(full),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .idle(idle)
  );

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      off[i] = 0;
    end
    rr = 0;
    ew = 0;
    ea = 0;
    ed = 0;
  endtask

  task automatic model_edge();
    int pre [4];
    int s;
    for (int i = 0; i < 4; i++) pre[i] = q[i].size();
    if (!ew || mem_ready) begin
      s = -1;
      for (int k = 0; k < 4; k++)
        if (s < 0 && pre[(rr + k) % 4] > 0) s = (rr + k) % 4;
      if (s >= 0) begin
        ew = 1;
        ed = int'(q[s].pop_front());
        ea = s * LANE_STRIDE + off[s];
        off[s] = (off[s] + 1) % LANE_STRIDE;
        rr = (s + 1) % 4;
      end else ew = 0;
    end
    for (int i = 0; i < 4; i++)
      if (push[i] && pre[i] < FIFO_DEPTH) q[i].push_back(din[i*8 +: 8]);
  endtask

  function automatic logic [23:0] exp_vec();
    logic [3:0] f;
    logic e;
    e = !ew;
    for (int i = 0; i < 4; i++) begin
      f[i] = q[i].size() == FIFO_DEPTH;
      if (q[i].size() != 0) e = 0;
    end
    return {ew, 10'(ea), 8'(ed), f, e};
  endfunction

  task automatic cycle(input logic [3:0] p, input logic [31:0] d);
    push = p;
    din = d;
    model_edge();
    @(posedge clk);
    #1;
    push = 0;
  endtask

  task automatic apply_reset();
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    #1 rst = 1;
    #1;
    total += 5;
    if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", mem_we); end
    if (mem_addr !== 10'd0) begin bad++; $display("FAIL reset_addr got=%h want=0", mem_addr); end
    if (mem_din !== 8'd0) begin bad++; $display("FAIL reset_din got=%h want=0", mem_din); end
    if (full !== 4'd0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
    if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b want=1", idle); end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    cycle(4'b0100, 32'h00A5_0000);
    total++;
    if (mem_we !== 1'b0) begin bad++; $display("FAIL single_early got=%b want=0", mem_we); end
    cycle(0, 0);
    total++;
    if ({mem_we, mem_addr, mem_din} !== {1'b1, 10'd512, 8'hA5})
      begin bad++; $display("FAIL single_write got=%b/%0d/%h want=1/512/a5", mem_we, mem_addr, mem_din); end
    cycle(0, 0);
    total++;
    if ({mem_we, idle} !== 2'b01) begin bad++; $display("FAIL single_idle got=%b%b want=01", mem_we, idle); end
  endtask

  task automatic test_all_lanes();
    apply_reset();
    cycle(4'hF, 32'h1312_1110);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0);
      total++;
      if ({mem_we, mem_addr, mem_din} !== {1'b1, 10'(i * 256), 8'(8'h10 + i)})
        begin bad++; $display("FAIL all_lanes i=%0d got=%b/%0d/%h want=1/%0d/%h", i, mem_we, mem_addr, mem_din, i * 256, 8'h10 + i); end
    end
  endtask

  task automatic test_saturate();
    logic saw_full = 0;
    apply_reset();
    for (int c = 0; c < 32; c++) begin
      cycle(c < 8 ? 4'hF : 4'h0, $urandom);
      if (|full) saw_full = 1;
      total++;
      if ({mem_we, mem_addr, mem_din, full, idle} !== exp_vec())
        begin bad++; $display("FAIL saturate cyc=%0d got=%h want=%h", c, {mem_we, mem_addr, mem_din, full, idle}, exp_vec()); end
    end
    total++;
    if (saw_full !== 1'b1) begin bad++; $display("FAIL saturate_full got=%b want=1", saw_full); end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int n = 0; n < 257; n++) begin
      cycle(4'b0010, 32'(n % 256) << 8);
      cycle(0, 0);
      total++;
      if ({mem_we, mem_addr, mem_din} !== {1'b1, 10'(256 + n % 256), 8'(n)})
        begin bad++; $display("FAIL wrap n=%0d got=%b/%0d/%h want=1/%0d/%h", n, mem_we, mem_addr, mem_din, 256 + n % 256, 8'(n)); end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cycle(4'b0001, 32'h31);
    cycle(4'b0001, 32'h32);
    cycle(4'b0001, 32'h33);
    total++;
    if (mem_we !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", mem_we); end
    #2 rst = 1;
    #1;
    total++;
    if ({mem_we, idle, full} !== 6'b010000) begin bad++; $display("FAIL mid_reset got=%b%b%b want=010000", mem_we, idle, full); end
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    cycle(4'b0001, 32'h77);
    cycle(0, 0);
    total++;
    if ({mem_we, mem_addr, mem_din} !== {1'b1, 10'd0, 8'h77})
      begin bad++; $display("FAIL mid_after got=%b/%0d/%h want=1/0/77", mem_we, mem_addr, mem_din); end
  endtask

`ifdef WB_READY_EN
  task automatic test_ready();
    apply_reset();
    mem_ready = 1;
    cycle(4'b0001, 32'hC0);
    cycle(4'b0001, 32'hC1);
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0001, 32'(8'hD0 + i));
      total++;
      if ({mem_we, mem_addr, mem_din} !== {1'b1, 10'd0, 8'hC0})
        begin bad++; $display("FAIL ready_hold i=%0d got=%b/%0d/%h want=1/0/c0", i, mem_we, mem_addr, mem_din); end
    end
    total++;
    if (full[0] !== 1'b1) begin bad++; $display("FAIL ready_full got=%b want=1", full[0]); end
    mem_ready = 1;
    cycle(0, 0);
    total++;
    if ({mem_we, mem_addr, mem_din} !== {1'b1, 10'd1, 8'hC1})
      begin bad++; $display("FAIL ready_resume got=%b/%0d/%h want=1/1/c1", mem_we, mem_addr, mem_din); end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0);
      total++;
      if ({mem_we, mem_addr, mem_din} !== {1'b1, 10'(i + 2), 8'(8'hD0 + i)})
        begin bad++; $display("FAIL ready_drain i=%0d got=%b/%0d/%h want=1/%0d/%h", i, mem_we, mem_addr, mem_din, i + 2, 8'hD0 + i); end
    end
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 440; c++) begin
`ifdef WB_READY_EN
      mem_ready = c >= 400 || $urandom_range(0, 3) != 0;
`endif
      cycle(c < 400 ? 4'($urandom) : 4'h0, $urandom);
      total++;
      if ({mem_we, mem_addr, mem_din, full, idle} !== exp_vec())
        begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", c, {mem_we, mem_addr, mem_din, full, idle}, exp_vec()); end
    end
    mem_ready = 1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_all_lanes();
    test_saturate();
    test_wrap();
    test_reset_mid();
`ifdef WB_READY_EN
    test_ready();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
